// File: rtl/trap_pkg.sv
// Shared definitions for the M-mode trap controller: CSR addresses, cause
// codes, CSR access modes and the trap-entry FSM state encoding.
package trap_pkg;

   // Machine CSR addresses
   localparam logic [11:0] CSR_MSTATUS  = 12'h300;
   localparam logic [11:0] CSR_MIE      = 12'h304;
   localparam logic [11:0] CSR_MTVEC    = 12'h305;
   localparam logic [11:0] CSR_MSCRATCH = 12'h340;
   localparam logic [11:0] CSR_MEPC     = 12'h341;
   localparam logic [11:0] CSR_MCAUSE   = 12'h342;
   localparam logic [11:0] CSR_MTVAL    = 12'h343;
   localparam logic [11:0] CSR_MIP      = 12'h344;

   // mstatus bit positions that are implemented
   localparam int MSTATUS_MIE_BIT  = 3;
   localparam int MSTATUS_MPIE_BIT = 7;

   // Exception cause codes; interrupt line i reports IRQ_CAUSE_BASE + i
   localparam int CAUSE_ILLEGAL  = 2;
   localparam int CAUSE_LFAULT   = 5;
   localparam int CAUSE_SFAULT   = 7;
   localparam int CAUSE_ECALL_M  = 11;
   localparam int IRQ_CAUSE_BASE = 16;

   // CSR write/set/clear operation codes
   localparam logic [1:0] WSC_NONE  = 2'b00;
   localparam logic [1:0] WSC_WRITE = 2'b01;
   localparam logic [1:0] WSC_SET   = 2'b10;
   localparam logic [1:0] WSC_CLEAR = 2'b11;

   typedef enum logic [1:0] {
      IDLE        = 2'd0,
      SAVE_EPC    = 2'd1,
      SAVE_CAUSE  = 2'd2,
      SAVE_STATUS = 2'd3
   } trap_state_t;

endpackage

// File: rtl/trap_csr_file.sv
// Machine CSR storage for the trap controller. Handles software R/W/S/C
// accesses and the side-port updates driven by trap entry and mret.
// Optional feature macro: VECTORED_MODE_EN (keeps mtvec[1:0] writable and
// reports vectored mode when mtvec[1:0] == 01).
module csr_file
   import trap_pkg::*;
#(
   parameter int               XLEN        = 32,
   parameter int               NUM_IRQ     = 4,
   parameter logic [XLEN-1:0]  MTVEC_RESET = '0
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               csr_we,
   input  logic [1:0]         csr_mode,
   input  logic [11:0]        csr_addr,
   input  logic [XLEN-1:0]    csr_op,
   output logic [XLEN-1:0]    csr_r_data,
   input  logic [NUM_IRQ-1:0] irq_in,
   input  logic               epc_we,
   input  logic [XLEN-1:0]    epc_d,
   input  logic               cause_we,
   input  logic [XLEN-1:0]    cause_d,
   input  logic [XLEN-1:0]    tval_d,
   input  logic               trap_status_we,
   input  logic               mret_we,
   output logic               status_mie,
   output logic [NUM_IRQ-1:0] irq_en,
   output logic [XLEN-1:0]    mtvec_base,
   output logic               mtvec_vec,
   output logic [XLEN-1:0]    mepc_q
);

`ifdef VECTORED_MODE_EN
   localparam logic [1:0] MTVEC_LOW_MASK = 2'b11;
`else
   localparam logic [1:0] MTVEC_LOW_MASK = 2'b00;
`endif
   localparam logic [XLEN-1:0] MTVEC_MASK = {{(XLEN-2){1'b1}}, MTVEC_LOW_MASK};

   logic            mie_b;
   logic            mpie_b;
   logic [XLEN-1:0] mie_q;
   logic [XLEN-1:0] mtvec_q;
   logic [XLEN-1:0] mscratch_q;
   logic [XLEN-1:0] mcause_q;
   logic [XLEN-1:0] mtval_q;
   logic [XLEN-1:0] wdata;

   function automatic logic [XLEN-1:0] apply_wsc(input logic [XLEN-1:0] old_v,
                                                 input logic [XLEN-1:0] op_v,
                                                 input logic [1:0]      mode);
      logic [XLEN-1:0] res;
      case (mode)
         WSC_WRITE: res = op_v;
         WSC_SET:   res = old_v | op_v;
         WSC_CLEAR: res = old_v & ~op_v;
         default:   res = old_v;
      endcase
      return res;
   endfunction

   assign status_mie = mie_b;
   assign irq_en     = mie_q[NUM_IRQ-1:0];
   assign mtvec_base = {mtvec_q[XLEN-1:2], 2'b00};
`ifdef VECTORED_MODE_EN
   assign mtvec_vec  = (mtvec_q[1:0] == 2'b01);
`else
   assign mtvec_vec  = 1'b0;
`endif
   assign wdata      = apply_wsc(csr_r_data, csr_op, csr_mode);

   // Combinational read of the addressed CSR (pre-write value)
   always_comb begin
      csr_r_data = '0;
      case (csr_addr)
         CSR_MSTATUS: begin
            csr_r_data[MSTATUS_MIE_BIT]  = mie_b;
            csr_r_data[MSTATUS_MPIE_BIT] = mpie_b;
         end
         CSR_MIE:      csr_r_data = mie_q;
         CSR_MTVEC:    csr_r_data = mtvec_q;
         CSR_MSCRATCH: csr_r_data = mscratch_q;
         CSR_MEPC:     csr_r_data = mepc_q;
         CSR_MCAUSE:   csr_r_data = mcause_q;
         CSR_MTVAL:    csr_r_data = mtval_q;
         CSR_MIP:      csr_r_data = XLEN'(irq_in);
         default:      csr_r_data = '0;
      endcase
   end

   // CSR state update: trap/mret side ports take precedence over software writes
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         mie_b      <= 1'b0;
         mpie_b     <= 1'b0;
         mie_q      <= '0;
         mtvec_q    <= MTVEC_RESET & MTVEC_MASK;
         mscratch_q <= '0;
         mepc_q     <= '0;
         mcause_q   <= '0;
         mtval_q    <= '0;
      end else begin
         if (trap_status_we) begin
            mpie_b <= mie_b;
            mie_b  <= 1'b0;
         end else if (mret_we) begin
            mie_b  <= mpie_b;
            mpie_b <= 1'b1;
         end else if (csr_we && csr_addr == CSR_MSTATUS) begin
            mie_b  <= wdata[MSTATUS_MIE_BIT];
            mpie_b <= wdata[MSTATUS_MPIE_BIT];
         end

         if (epc_we)
            mepc_q <= {epc_d[XLEN-1:2], 2'b00};
         else if (csr_we && csr_addr == CSR_MEPC)
            mepc_q <= {wdata[XLEN-1:2], 2'b00};

         if (cause_we) begin
            mcause_q <= cause_d;
            mtval_q  <= tval_d;
         end else if (csr_we) begin
            if (csr_addr == CSR_MCAUSE) mcause_q <= wdata;
            if (csr_addr == CSR_MTVAL)  mtval_q  <= wdata;
         end

         if (csr_we) begin
            if (csr_addr == CSR_MIE)      mie_q      <= wdata;
            if (csr_addr == CSR_MTVEC)    mtvec_q    <= wdata & MTVEC_MASK;
            if (csr_addr == CSR_MSCRATCH) mscratch_q <= wdata;
         end
      end
   end

endmodule

// File: rtl/trap_unit.sv
// M-mode trap controller at MEM/WB: prioritises exceptions and maskable
// interrupts, runs the three-step trap-entry sequence, handles mret and
// drives flush/stall/redirect. CSR storage lives in csr_file.
// Optional feature macro: VECTORED_MODE_EN (vectored interrupt targets).
module trap_unit
   import trap_pkg::*;
#(
   parameter int               XLEN        = 32,
   parameter int               NUM_IRQ     = 4,
   parameter logic [XLEN-1:0]  MTVEC_RESET = '0
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               csr_rw_in,
   input  logic [1:0]         csr_wsc_mode_in,
   input  logic               csr_w_imm_mux,
   input  logic [11:0]        csr_rw_addr_in,
   input  logic [XLEN-1:0]    csr_w_data_reg,
   input  logic [4:0]         csr_w_data_imm,
   output logic [XLEN-1:0]    csr_r_data_out,
   input  logic [NUM_IRQ-1:0] irq_in,
   input  logic               illegal_inst,
   input  logic               ecall_m,
   input  logic               l_access_fault,
   input  logic               s_access_fault,
   input  logic [XLEN-1:0]    bad_addr,
   input  logic               mret,
   input  logic [XLEN-1:0]    epc_cur,
   input  logic [XLEN-1:0]    epc_next,
   output logic [XLEN-1:0]    pc_redirect,
   output logic               redirect_mux,
   output logic               reg_FD_flush,
   output logic               reg_DE_flush,
   output logic               reg_EM_flush,
   output logic               reg_MW_flush,
   output logic               RegWrite_cancel,
   output logic               trap_busy
);

   trap_state_t        state_q, state_d;
   logic [XLEN-1:0]    csr_op;
   logic               csr_we, mret_we, epc_we, cause_we, status_we, trap_fire;
   logic               status_mie, mtvec_vec;
   logic [NUM_IRQ-1:0] irq_en, pending;
   logic [XLEN-1:0]    mtvec_base, mepc_q;
   logic               exc_req, exc_fault, irq_req;
   logic [XLEN-1:0]    exc_cause, irq_cause, trap_target;
   logic [XLEN-1:0]    epc_h, cause_h, tval_h;
   logic               irq_h;

   assign csr_op  = csr_w_imm_mux ? XLEN'(csr_w_data_imm) : csr_w_data_reg;
   assign pending = irq_in & irq_en;
   assign exc_req = illegal_inst | ecall_m | l_access_fault | s_access_fault;
   assign irq_req = status_mie & (|pending);

   csr_file #(
      .XLEN        (XLEN),
      .NUM_IRQ     (NUM_IRQ),
      .MTVEC_RESET (MTVEC_RESET)
   ) u_csr_file (
      .clk            (clk),
      .rst            (rst),
      .csr_we         (csr_we),
      .csr_mode       (csr_wsc_mode_in),
      .csr_addr       (csr_rw_addr_in),
      .csr_op         (csr_op),
      .csr_r_data     (csr_r_data_out),
      .irq_in         (irq_in),
      .epc_we         (epc_we),
      .epc_d          (epc_h),
      .cause_we       (cause_we),
      .cause_d        (cause_h),
      .tval_d         (tval_h),
      .trap_status_we (status_we),
      .mret_we        (mret_we),
      .status_mie     (status_mie),
      .irq_en         (irq_en),
      .mtvec_base     (mtvec_base),
      .mtvec_vec      (mtvec_vec),
      .mepc_q         (mepc_q)
   );

   // Exception priority and lowest-index pending interrupt selection
   always_comb begin
      exc_cause = XLEN'(CAUSE_SFAULT);
      exc_fault = 1'b1;
      if (illegal_inst) begin
         exc_cause = XLEN'(CAUSE_ILLEGAL);
         exc_fault = 1'b0;
      end else if (ecall_m) begin
         exc_cause = XLEN'(CAUSE_ECALL_M);
         exc_fault = 1'b0;
      end else if (l_access_fault) begin
         exc_cause = XLEN'(CAUSE_LFAULT);
      end
      irq_cause = '0;
      for (int i = NUM_IRQ - 1; i >= 0; i--) begin
         if (pending[i]) irq_cause = XLEN'(IRQ_CAUSE_BASE + i);
      end
      irq_cause[XLEN-1] = 1'b1;
   end

   // Trap vector: vectored mode offsets interrupts by 4*cause code
   always_comb begin
      trap_target = mtvec_base;
      if (mtvec_vec && irq_h)
         trap_target = mtvec_base + {cause_h[XLEN-3:0], 2'b00};
   end

   // FSM next state and pipeline control outputs
   always_comb begin
      state_d         = state_q;
      pc_redirect     = '0;
      redirect_mux    = 1'b0;
      reg_FD_flush    = 1'b0;
      reg_DE_flush    = 1'b0;
      reg_EM_flush    = 1'b0;
      reg_MW_flush    = 1'b0;
      RegWrite_cancel = 1'b0;
      trap_busy       = 1'b0;
      csr_we          = 1'b0;
      mret_we         = 1'b0;
      epc_we          = 1'b0;
      cause_we        = 1'b0;
      status_we       = 1'b0;
      trap_fire       = 1'b0;
      case (state_q)
         IDLE: begin
            if (exc_req || (!mret && irq_req)) begin
               trap_fire       = 1'b1;
               reg_FD_flush    = 1'b1;
               reg_DE_flush    = 1'b1;
               reg_EM_flush    = 1'b1;
               reg_MW_flush    = 1'b1;
               RegWrite_cancel = exc_req;
               state_d         = SAVE_EPC;
            end else if (mret) begin
               mret_we      = 1'b1;
               redirect_mux = 1'b1;
               pc_redirect  = mepc_q;
               reg_FD_flush = 1'b1;
               reg_DE_flush = 1'b1;
               reg_EM_flush = 1'b1;
            end else begin
               csr_we = csr_rw_in && (csr_wsc_mode_in != WSC_NONE);
            end
         end
         SAVE_EPC: begin
            trap_busy = 1'b1;
            epc_we    = 1'b1;
            state_d   = SAVE_CAUSE;
         end
         SAVE_CAUSE: begin
            trap_busy = 1'b1;
            cause_we  = 1'b1;
            state_d   = SAVE_STATUS;
         end
         SAVE_STATUS: begin
            trap_busy    = 1'b1;
            status_we    = 1'b1;
            redirect_mux = 1'b1;
            pc_redirect  = trap_target;
            state_d      = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // FSM state register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= IDLE;
      else     state_q <= state_d;
   end

   // Capture trap context at the detect edge; inputs are ignored while busy
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         epc_h   <= '0;
         cause_h <= '0;
         tval_h  <= '0;
         irq_h   <= 1'b0;
      end else if (trap_fire) begin
         epc_h   <= exc_req ? epc_cur : epc_next;
         cause_h <= exc_req ? exc_cause : irq_cause;
         tval_h  <= (exc_req && exc_fault) ? bad_addr : '0;
         irq_h   <= !exc_req;
      end
   end

endmodule

// File: tb/tb_trap_unit.sv
// Directed self-checking bench for trap_unit. Build with +define+VECTORED_MODE_EN
// to exercise vectored interrupt targets.
module tb_trap_unit;

   logic        clk = 1'b0;
   logic        rst;
   logic        csr_rw_in;
   logic [1:0]  csr_wsc_mode_in;
   logic        csr_w_imm_mux;
   logic [11:0] csr_rw_addr_in;
   logic [31:0] csr_w_data_reg;
   logic [4:0]  csr_w_data_imm;
   logic [31:0] csr_r_data_out;
   logic [3:0]  irq_in;
   logic        illegal_inst, ecall_m, l_access_fault, s_access_fault;
   logic [31:0] bad_addr;
   logic        mret;
   logic [31:0] epc_cur, epc_next;
   logic [31:0] pc_redirect;
   logic        redirect_mux;
   logic        reg_FD_flush, reg_DE_flush, reg_EM_flush, reg_MW_flush;
   logic        RegWrite_cancel, trap_busy;

   int n_asserts = 0;
   int n_fail    = 0;
   logic [31:0] rdv;

`ifdef VECTORED_MODE_EN
   localparam logic [31:0] EXP_MTVEC_RD = 32'h101;
   localparam logic [31:0] EXP_IRQ0_TGT = 32'h140;
`else
   localparam logic [31:0] EXP_MTVEC_RD = 32'h100;
   localparam logic [31:0] EXP_IRQ0_TGT = 32'h100;
`endif

   trap_unit #(.XLEN(32), .NUM_IRQ(4), .MTVEC_RESET(32'h0)) dut (
      .clk(clk), .rst(rst), .csr_rw_in(csr_rw_in), .csr_wsc_mode_in(csr_wsc_mode_in),
      .csr_w_imm_mux(csr_w_imm_mux), .csr_rw_addr_in(csr_rw_addr_in),
      .csr_w_data_reg(csr_w_data_reg), .csr_w_data_imm(csr_w_data_imm),
      .csr_r_data_out(csr_r_data_out), .irq_in(irq_in), .illegal_inst(illegal_inst),
      .ecall_m(ecall_m), .l_access_fault(l_access_fault), .s_access_fault(s_access_fault),
      .bad_addr(bad_addr), .mret(mret), .epc_cur(epc_cur), .epc_next(epc_next),
      .pc_redirect(pc_redirect), .redirect_mux(redirect_mux),
      .reg_FD_flush(reg_FD_flush), .reg_DE_flush(reg_DE_flush),
      .reg_EM_flush(reg_EM_flush), .reg_MW_flush(reg_MW_flush),
      .RegWrite_cancel(RegWrite_cancel), .trap_busy(trap_busy)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_asserts++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic check_ctl(input string tag, input logic [3:0] fl, input logic cancel,
                            input logic busy, input logic redir, input logic [31:0] pc);
      check({tag, "_flush"},  {28'h0, reg_FD_flush, reg_DE_flush, reg_EM_flush, reg_MW_flush}, {28'h0, fl});
      check({tag, "_cancel"}, {31'h0, RegWrite_cancel}, {31'h0, cancel});
      check({tag, "_busy"},   {31'h0, trap_busy}, {31'h0, busy});
      check({tag, "_redir"},  {31'h0, redirect_mux}, {31'h0, redir});
      if (redir) check({tag, "_pc"}, pc_redirect, pc);
   endtask

   // One CSR instruction: read value sampled before the committing edge
   task automatic csr_op(input logic [1:0] mode, input logic [11:0] addr, input logic imm_sel,
                         input logic [31:0] regv, input logic [4:0] immv, output logic [31:0] rd);
      @(negedge clk);
      csr_rw_in = 1'b1; csr_wsc_mode_in = mode; csr_rw_addr_in = addr;
      csr_w_imm_mux = imm_sel; csr_w_data_reg = regv; csr_w_data_imm = immv;
      #1 rd = csr_r_data_out;
      @(posedge clk);
      #1 csr_rw_in = 1'b0; csr_wsc_mode_in = 2'b00;
   endtask

   task automatic rd_csr(input logic [11:0] addr, output logic [31:0] rd);
      @(negedge clk);
      csr_rw_addr_in = addr;
      #1 rd = csr_r_data_out;
   endtask

   initial begin
      rst = 1'b1; csr_rw_in = 0; csr_wsc_mode_in = 0; csr_w_imm_mux = 0; csr_rw_addr_in = 0;
      csr_w_data_reg = 0; csr_w_data_imm = 0; irq_in = 0; illegal_inst = 0; ecall_m = 0;
      l_access_fault = 0; s_access_fault = 0; bad_addr = 0; mret = 0; epc_cur = 0; epc_next = 0;

      // Reset state
      repeat (2) @(negedge clk);
      #1 check_ctl("reset", 4'h0, 0, 0, 0, 0);
      check("reset_pc", pc_redirect, 32'h0);
      rd_csr(12'h305, rdv); check("reset_mtvec", rdv, 32'h0);
      rd_csr(12'h300, rdv); check("reset_mstatus", rdv, 32'h0);
      @(negedge clk) rst = 1'b0;

      // 1: W / S-imm / C-imm on mscratch
      csr_op(2'b01, 12'h340, 0, 32'hA5A5, 5'd0, rdv); check("t1_rd0", rdv, 32'h0);
      csr_op(2'b10, 12'h340, 1, 32'hFFFF_FFFF, 5'd2, rdv); check("t1_rd1", rdv, 32'hA5A5);
      csr_op(2'b11, 12'h340, 1, 32'hFFFF_FFFF, 5'd1, rdv); check("t1_rd2", rdv, 32'hA5A7);
      rd_csr(12'h340, rdv); check("t1_final", rdv, 32'hA5A6);
      rd_csr(12'h3FF, rdv); check("t1_unmapped", rdv, 32'h0);

      // 2: illegal instruction with a concurrent (dropped) CSR write
      csr_op(2'b01, 12'h305, 0, 32'h80, 5'd0, rdv);
      @(negedge clk);
      illegal_inst = 1; epc_cur = 32'h100;
      csr_rw_in = 1; csr_wsc_mode_in = 2'b01; csr_rw_addr_in = 12'h340; csr_w_data_reg = 32'hFFFF;
      #1 check_ctl("t2_detect", 4'hF, 1, 0, 0, 0);
      @(negedge clk);
      illegal_inst = 0; csr_rw_in = 0; csr_wsc_mode_in = 0; ecall_m = 1;
      #1 check_ctl("t2_epc", 4'h0, 0, 1, 0, 0);
      @(negedge clk); #1 check_ctl("t2_cause", 4'h0, 0, 1, 0, 0);
      @(negedge clk); ecall_m = 0;
      #1 check_ctl("t2_status", 4'h0, 0, 1, 1, 32'h80);
      @(negedge clk); #1 check_ctl("t2_idle", 4'h0, 0, 0, 0, 0);
      rd_csr(12'h341, rdv); check("t2_mepc", rdv, 32'h100);
      rd_csr(12'h342, rdv); check("t2_mcause", rdv, 32'h2);
      rd_csr(12'h343, rdv); check("t2_mtval", rdv, 32'h0);
      rd_csr(12'h340, rdv); check("t2_mscratch_kept", rdv, 32'hA5A6);

      // 3: interrupt (line 1 masked, line 2 enabled), irq dropped mid-sequence
      csr_op(2'b01, 12'h300, 0, 32'h8, 5'd0, rdv);
      csr_op(2'b01, 12'h304, 0, 32'h4, 5'd0, rdv);
      @(negedge clk);
      irq_in = 4'b0110; epc_next = 32'h204; epc_cur = 32'h999;
      #1 check_ctl("t3_detect", 4'hF, 0, 0, 0, 0);
      @(negedge clk); irq_in = 0;
      #1 check_ctl("t3_epc", 4'h0, 0, 1, 0, 0);
      @(negedge clk); #1 check_ctl("t3_cause", 4'h0, 0, 1, 0, 0);
      @(negedge clk); #1 check_ctl("t3_status", 4'h0, 0, 1, 1, 32'h80);
      @(negedge clk); #1 check_ctl("t3_idle", 4'h0, 0, 0, 0, 0);
      rd_csr(12'h341, rdv); check("t3_mepc", rdv, 32'h204);
      rd_csr(12'h342, rdv); check("t3_mcause", rdv, 32'h8000_0012);
      rd_csr(12'h300, rdv); check("t3_mstatus", rdv, 32'h80);

      // 4: mret
      @(negedge clk); mret = 1;
      #1 check_ctl("t4_mret", 4'hE, 0, 0, 1, 32'h204);
      @(negedge clk); mret = 0;
      #1 check_ctl("t4_after", 4'h0, 0, 0, 0, 0);
      rd_csr(12'h300, rdv); check("t4_mstatus", rdv, 32'h88);

      // 5: load+store fault+irq together; irq pending until mret
      csr_op(2'b01, 12'h304, 0, 32'h6, 5'd0, rdv);
      @(negedge clk);
      l_access_fault = 1; s_access_fault = 1; irq_in = 4'b0110; bad_addr = 32'hDEAD;
      epc_cur = 32'h300; epc_next = 32'h304;
      #1 check_ctl("t5_detect", 4'hF, 1, 0, 0, 0);
      @(negedge clk); l_access_fault = 0; s_access_fault = 0;
      #1 check_ctl("t5_epc", 4'h0, 0, 1, 0, 0);
      @(negedge clk); #1 check_ctl("t5_cause", 4'h0, 0, 1, 0, 0);
      @(negedge clk); #1 check_ctl("t5_status", 4'h0, 0, 1, 1, 32'h80);
      rd_csr(12'h342, rdv); check("t5_mcause", rdv, 32'h5);
      rd_csr(12'h343, rdv); check("t5_mtval", rdv, 32'hDEAD);
      rd_csr(12'h341, rdv); check("t5_mepc", rdv, 32'h300);
      rd_csr(12'h300, rdv); check("t5_mstatus", rdv, 32'h80);
      check_ctl("t5_masked", 4'h0, 0, 0, 0, 0);
      @(negedge clk); mret = 1;
      #1 check_ctl("t5_mret_wins", 4'hE, 0, 0, 1, 32'h300);
      @(negedge clk); mret = 0;
      #1 check_ctl("t5_irq_detect", 4'hF, 0, 0, 0, 0);
      @(negedge clk); irq_in = 0;
      #1 check_ctl("t5_irq_epc", 4'h0, 0, 1, 0, 0);
      @(negedge clk); #1 check_ctl("t5_irq_cause", 4'h0, 0, 1, 0, 0);
      @(negedge clk); #1 check_ctl("t5_irq_status", 4'h0, 0, 1, 1, 32'h80);
      rd_csr(12'h342, rdv); check("t5_irq_mcause", rdv, 32'h8000_0011);
      rd_csr(12'h341, rdv); check("t5_irq_mepc", rdv, 32'h304);
      rd_csr(12'h343, rdv); check("t5_irq_mtval", rdv, 32'h0);

      // 6: mtvec mode bits, irq line 0 target, reset during SAVE_CAUSE
      csr_op(2'b01, 12'h305, 0, 32'h101, 5'd0, rdv);
      rd_csr(12'h305, rdv); check("t6_mtvec", rdv, EXP_MTVEC_RD);
      csr_op(2'b01, 12'h304, 0, 32'h1, 5'd0, rdv);
      csr_op(2'b10, 12'h300, 1, 32'h0, 5'd8, rdv);
      @(negedge clk); irq_in = 4'b0001; epc_next = 32'h400;
      #1 check_ctl("t6_detect", 4'hF, 0, 0, 0, 0);
      @(negedge clk); #1 check_ctl("t6_epc", 4'h0, 0, 1, 0, 0);
      @(negedge clk); #1 check_ctl("t6_cause", 4'h0, 0, 1, 0, 0);
      @(negedge clk); #1 check_ctl("t6_status", 4'h0, 0, 1, 1, EXP_IRQ0_TGT);
      @(negedge clk); mret = 1;
      #1 check_ctl("t6_mret", 4'hE, 0, 0, 1, 32'h400);
      @(negedge clk); mret = 0;
      #1 check_ctl("t6_redetect", 4'hF, 0, 0, 0, 0);
      @(negedge clk); #1 check_ctl("t6_epc2", 4'h0, 0, 1, 0, 0);
      @(negedge clk); #1 check_ctl("t6_cause2", 4'h0, 0, 1, 0, 0);
      #1 rst = 1'b1;
      #1 check_ctl("t6_rst", 4'h0, 0, 0, 0, 0);
      rd_csr(12'h305, rdv); check("t6_rst_mtvec", rdv, 32'h0);
      rd_csr(12'h300, rdv); check("t6_rst_mstatus", rdv, 32'h0);
      rd_csr(12'h341, rdv); check("t6_rst_mepc", rdv, 32'h0);
      rd_csr(12'h342, rdv); check("t6_rst_mcause", rdv, 32'h0);
      rd_csr(12'h340, rdv); check("t6_rst_mscratch", rdv, 32'h0);
      rd_csr(12'h304, rdv); check("t6_rst_mie", rdv, 32'h0);
      rd_csr(12'h344, rdv); check("t6_mip", rdv, 32'h1);
      @(negedge clk); rst = 1'b0;
      repeat (2) @(negedge clk);
      #1 check_ctl("t6_post", 4'h0, 0, 0, 0, 0);
      irq_in = 0;

      $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
      $finish;
   end

endmodule
